fetch_unit: RTL

Instruction fetch stage for the myMIPS core, sitting directly upstream of the instruction ROM and downstream-feeding decode. It owns the program counter and drives the ROM read port (read enable and address). It tags the 1-cycle-latency ROM data with its PC and buffers it in a 2-entry FIFO. The FIFO presents instructions to decode over a valid/ready handshake. Branch and jump redirects flush the FIFO and squash any in-flight read.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM read port,
// tags returning ROM data with its PC and buffers it in a 2-entry FIFO that
// feeds decode over a valid/ready handshake. Redirects flush everything.
module fetch_unit #(
    parameter int unsigned       AWIDTH   = 8,
    parameter int unsigned       DWIDTH   = 16,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_rom_rd,
    output logic [AWIDTH-1:0] o_rom_raddr,
    input  logic [DWIDTH-1:0] i_rom_rdata,
    input  logic              i_redirect,
    input  logic [AWIDTH-1:0] i_redirect_pc,
    output logic              o_instr_valid,
    output logic [DWIDTH-1:0] o_instr,
    output logic [AWIDTH-1:0] o_instr_pc,
    input  logic              i_instr_ready
);

    localparam logic [AWIDTH-1:0] PcOne = {{(AWIDTH-1){1'b0}}, 1'b1};

    // Fetch state
    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] tag_pc_q;
    logic              inflight_q;

    // FIFO storage; entry 0 is always the head
    logic [AWIDTH-1:0] ent_pc_q    [2];
    logic [DWIDTH-1:0] ent_instr_q [2];
    logic [AWIDTH-1:0] ent_pc_d    [2];
    logic [DWIDTH-1:0] ent_instr_d [2];
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    // Handshake / control
    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occ_after_pop;

    // Head presentation, forced to zero while empty or in reset
    always_comb begin
        o_instr_valid = ~rst & (count_q != 2'd0);
        o_instr       = o_instr_valid ? ent_instr_q[0] : '0;
        o_instr_pc    = o_instr_valid ? ent_pc_q[0] : '0;
    end

    // Issue decision: never let buffered + in-flight words exceed the FIFO depth
    always_comb begin
        pop           = o_instr_valid & i_instr_ready;
        // Data for an in-flight read is captured unless this cycle flushes
        push          = inflight_q & ~i_redirect & ~rst;
        occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue         = ~rst & ~i_redirect & (occ_after_pop < 3'd2);
        o_rom_rd      = issue;
        o_rom_raddr   = pc_q;
    end

    // FIFO next state: flush beats everything, otherwise shift-on-pop / append-on-push
    always_comb begin
        count_d        = count_q;
        ent_pc_d[0]    = ent_pc_q[0];
        ent_pc_d[1]    = ent_pc_q[1];
        ent_instr_d[0] = ent_instr_q[0];
        ent_instr_d[1] = ent_instr_q[1];
        if (i_redirect) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b01: begin
                    ent_pc_d[0]    = ent_pc_q[1];
                    ent_instr_d[0] = ent_instr_q[1];
                    count_d        = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent_pc_d[0]    = tag_pc_q;
                        ent_instr_d[0] = i_rom_rdata;
                    end else begin
                        ent_pc_d[1]    = tag_pc_q;
                        ent_instr_d[1] = i_rom_rdata;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // Count unchanged; new word lands behind whatever survives the pop
                    if (count_q == 2'd1) begin
                        ent_pc_d[0]    = tag_pc_q;
                        ent_instr_d[0] = i_rom_rdata;
                    end else begin
                        ent_pc_d[0]    = ent_pc_q[1];
                        ent_instr_d[0] = ent_instr_q[1];
                        ent_pc_d[1]    = tag_pc_q;
                        ent_instr_d[1] = i_rom_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // PC, in-flight tag and FIFO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            tag_pc_q       <= RESET_PC;
            inflight_q     <= 1'b0;
            count_q        <= 2'd0;
            ent_pc_q[0]    <= '0;
            ent_pc_q[1]    <= '0;
            ent_instr_q[0] <= '0;
            ent_instr_q[1] <= '0;
        end else begin
            count_q        <= count_d;
            ent_pc_q[0]    <= ent_pc_d[0];
            ent_pc_q[1]    <= ent_pc_d[1];
            ent_instr_q[0] <= ent_instr_d[0];
            ent_instr_q[1] <= ent_instr_d[1];
            // A redirect squashes the in-flight read because issue is low here
            inflight_q     <= issue;
            if (i_redirect) begin
                pc_q <= i_redirect_pc;
            end else if (issue) begin
                pc_q     <= pc_q + PcOne;
                tag_pc_q <= pc_q;
            end
        end
    end

    // Overflow is impossible by construction of the issue rule
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && !i_redirect && count_q == 2'd2))
            else $error("fetch_unit: push into a full FIFO");
        end
    end

endmodule
